// File: rtl/route_chk_pkg.sv
// Shared types and helpers for the routing-loop checker: FSM states,
// the Fibonacci XNOR LFSR step and per-channel seed derivation.
package route_chk_pkg;

    localparam int LFSR_W = 16;
    // Taps 16,15,13,4 expressed as bit positions 15,14,12,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hD008;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ~(^(cur & LFSR_TAPS))};
    endfunction

    // Rotate the base seed left by the channel index; an all-zero result becomes 1
    function automatic logic [LFSR_W-1:0] chan_seed(input int c,
                                                    input logic [LFSR_W-1:0] base = SEED_DEFAULT);
        logic [LFSR_W-1:0] r;
        int k;
        k = c % LFSR_W;
        r = base;
        for (int i = 0; i < k; i++) begin
            r = {r[LFSR_W-2:0], r[LFSR_W-1]};
        end
        if (r == '0) begin
            r = {{(LFSR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/route_loop_checker_channel.sv
// One loop channel: LFSR, transmit register, expected-bit delay line,
// return capture flop, comparator and saturating mismatch counter.
module rlc_channel
    import route_chk_pkg::*;
#(
    parameter int                HOPS    = 1,
    parameter int                ERR_W   = 16,
    parameter logic [LFSR_W-1:0] CH_SEED = SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             compare,
    input  logic             inj,
    input  logic             loop_i,
    output logic             loop_o,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int               DEPTH   = HOPS + 1;
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    logic [LFSR_W-1:0] lfsr_reg;
    logic              tx_reg;
    logic              inv_reg;
    logic              cap_reg;
    logic [DEPTH-1:0]  exp_line_reg;
    logic [DEPTH-1:0]  inv_line_reg;
    logic              err_flag_reg;
    logic [ERR_W-1:0]  err_cnt_reg;
    logic              mismatch;

    // The inversion line cancels a deliberate injection, so an intact loop flags it exactly once
    assign mismatch = cap_reg != (exp_line_reg[DEPTH-1] ^ inv_line_reg[DEPTH-1]);
    assign loop_o   = tx_reg;
    assign err_flag = err_flag_reg;
    assign err_cnt  = err_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_reg     <= CH_SEED;
            tx_reg       <= 1'b0;
            inv_reg      <= 1'b0;
            cap_reg      <= 1'b0;
            exp_line_reg <= '0;
            inv_line_reg <= '0;
        end else begin
            cap_reg      <= loop_i;
            exp_line_reg <= {exp_line_reg[DEPTH-2:0], tx_reg};
            inv_line_reg <= {inv_line_reg[DEPTH-2:0], inv_reg};
            inv_reg      <= 1'b0;
            if (load) begin
                lfsr_reg <= CH_SEED;
            end else if (step) begin
                lfsr_reg <= lfsr_next(lfsr_reg);
                tx_reg   <= lfsr_reg[LFSR_W-1] ^ inj;
                inv_reg  <= inj;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            err_flag_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else if (compare && mismatch) begin
            err_flag_reg <= 1'b1;
            if (err_cnt_reg != CNT_MAX) begin
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
            end
        end
    end

endmodule

// File: rtl/route_loop_checker.sv
// Top of the loop checker: run-control FSM, prime counter and injection
// decode around CHANNELS independent loop channels.
module route_loop_checker
    import route_chk_pkg::*;
#(
    parameter int                CHANNELS = 4,
    parameter int                HOPS     = 1,
    parameter logic [LFSR_W-1:0] SEED     = SEED_DEFAULT,
    parameter int                ERR_W    = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         stop,
    input  logic                                         inj_en,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] inj_ch,
    output logic [CHANNELS-1:0]                          loop_o,
    input  logic [CHANNELS-1:0]                          loop_i,
    output logic                                         busy,
    output logic                                         checking,
    output logic [CHANNELS-1:0]                          err_flag,
    output logic [CHANNELS*ERR_W-1:0]                    err_cnt
);

    localparam int                 CH_W      = $clog2(CHANNELS > 1 ? CHANNELS : 2);
    localparam int                 PRIME_W   = $clog2(HOPS + 2);
    localparam logic [PRIME_W-1:0] PRIME_LEN = PRIME_W'(HOPS + 1);

    state_t               state_reg, state_next;
    logic [PRIME_W-1:0]   prime_cnt_reg, prime_cnt_next;
    logic                 load;
    logic [CHANNELS-1:0]  inj_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            prime_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            prime_cnt_reg <= prime_cnt_next;
        end
    end

    // stop only matters in PRIME/RUN and start only in IDLE/HALT, so a simultaneous pair resolves by state
    always_comb begin
        state_next     = state_reg;
        prime_cnt_next = prime_cnt_reg;
        load           = 1'b0;
        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    state_next     = PRIME;
                    prime_cnt_next = PRIME_LEN;
                    load           = 1'b1;
                end
            end
            PRIME: begin
                if (stop) begin
                    state_next = HALT;
                end else begin
                    prime_cnt_next = prime_cnt_reg - PRIME_W'(1);
                    if (prime_cnt_reg == PRIME_W'(1)) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = HALT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg == PRIME) || (state_reg == RUN);
    assign checking = (state_reg == RUN);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign inj_vec[gi] = inj_en && busy && (inj_ch == CH_W'(gi));

            rlc_channel #(
                .HOPS    (HOPS),
                .ERR_W   (ERR_W),
                .CH_SEED (chan_seed(gi, SEED))
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (load),
                .step     (busy),
                .compare  (checking),
                .inj      (inj_vec[gi]),
                .loop_i   (loop_i[gi]),
                .loop_o   (loop_o[gi]),
                .err_flag (err_flag[gi]),
                .err_cnt  (err_cnt[gi*ERR_W +: ERR_W])
            );
        end
    endgenerate

endmodule
